// File: rtl/sub_serial_pkg.sv
// Shared types and default sizing for the digit-serial subtractor.
package sub_serial_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;
endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtract with borrow in/out.
module sub_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             borrow_in,
    output logic [DIGIT-1:0] diff,
    output logic             borrow_out
);
    logic [DIGIT:0] wide;

    // The extra top bit of the widened difference is the borrow out.
    assign wide       = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, borrow_in};
    assign diff       = wide[DIGIT-1:0];
    assign borrow_out = wide[DIGIT];
endmodule

// File: rtl/sub_serial.sv
// Digit-serial unsigned subtractor: one DIGIT slice per cycle, LSB first.
// Optional macro SUB_SERIAL_CONDSUB_EN adds a cond input selecting ina when the result borrows.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SUB_SERIAL_CONDSUB_EN
    input  logic             cond,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             borrow
);
    localparam int NSL = WIDTH / DIGIT;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    sub_state_t state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             brw_q;
    logic [DIGIT-1:0] d_slice;
    logic             d_bo;
    logic             accept;

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a          (a_q[cnt*DIGIT +: DIGIT]),
        .b          (b_q[cnt*DIGIT +: DIGIT]),
        .borrow_in  (brw_q),
        .diff       (d_slice),
        .borrow_out (d_bo)
    );

    assign accept = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN:  if (cnt == LAST) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            brw_q <= 1'b0;
        end else if (accept) begin
            a_q   <= ina;
            b_q   <= inb;
            cnt   <= '0;
            brw_q <= 1'b0;
        end else if (state == RUN) begin
            res_q[cnt*DIGIT +: DIGIT] <= d_slice;
            brw_q <= d_bo;
            cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign borrow = brw_q;

`ifdef SUB_SERIAL_CONDSUB_EN
    logic cond_q;

    always_ff @(posedge clk) begin
        if (!rst_n)      cond_q <= 1'b0;
        else if (accept) cond_q <= cond;
    end

    // Conditional reduction: keep the minuend when the subtraction underflows.
    assign result = (cond_q && brw_q) ? a_q : res_q;
`else
    assign result = res_q;
`endif
endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial: vector table plus handshake/reset sequences.
module tb_sub_serial;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, borrow;
    logic [W-1:0] ina, inb, result;
`ifdef SUB_SERIAL_CONDSUB_EN
    logic         cond;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] exp_res;
        logic         exp_brw;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sub_serial #(.WIDTH(W), .DIGIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SUB_SERIAL_CONDSUB_EN
        .cond      (cond),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ina       (ina),
        .inb       (inb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .borrow    (borrow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_cond(input logic c);
`ifdef SUB_SERIAL_CONDSUB_EN
        cond = c;
`endif
    endtask

    // Drive one operation from a negedge; returns at the negedge after the output pop.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] er, input logic eb, input int hold, input string nm);
        int lat;
        int k;
        k = 0;
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        check({nm, " ready_wait"}, 64'(in_ready), 64'd1);
        ina = a; inb = b; set_cond(c); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ina = ~a; inb = ~b; set_cond(~c);
        check({nm, " in_ready_run"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        check({nm, " latency"}, 64'(lat), 64'd4);
        check({nm, " result"}, 64'(result), 64'(er));
        check({nm, " borrow"}, 64'(borrow), 64'(eb));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({nm, " hold_valid"}, 64'(out_valid), 64'd1);
            check({nm, " hold_ready"}, 64'(in_ready), 64'd0);
            check({nm, " hold_result"}, 64'(result), 64'(er));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, " pop_valid"}, 64'(out_valid), 64'd0);
        check({nm, " pop_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ina = '0; inb = '0; set_cond(1'b0);
        vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0});
        vecs.push_back('{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0});
        vecs.push_back('{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h8ACF_1357, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0});
`ifdef SUB_SERIAL_CONDSUB_EN
        vecs.push_back('{32'h0000_0003, 32'h0000_0005, 1'b1, 32'h0000_0003, 1'b1});
        vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b0});
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst result", 64'(result), 64'd0);
        check("rst borrow", 64'(borrow), 64'd0);

        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_res, vecs[i].exp_brw, 0,
                  $sformatf("vec%0d", i));

        // Back-pressure hold, then immediate second operation.
        do_op(32'h10, 32'h01, 1'b0, 32'h0000_000F, 1'b0, 3, "hold");
        do_op(32'h20, 32'h01, 1'b0, 32'h0000_001F, 1'b0, 0, "after_hold");

        // in_valid raised with out_ready in DONE must not be accepted that cycle.
        ina = 32'h7; inb = 32'h2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        ina = 32'h44; inb = 32'h11; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("done_no_accept valid", 64'(out_valid), 64'd0);
        check("done_no_accept ready", 64'(in_ready), 64'd1);
        check("done_no_accept result", 64'(result), 64'h5);
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_accept ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        check("idle_accept result", 64'(result), 64'h33);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the second RUN cycle aborts the operation.
        ina = 32'hFFFF_FFFF; inb = 32'h1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort in_ready", 64'(in_ready), 64'd1);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("abort no out_valid", 64'(seen), 64'd0);
        end
        do_op(32'h9, 32'h4, 1'b0, 32'h0000_0005, 1'b0, 0, "post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
